seven_seg_capture: RTL
======================

# seven_seg_capture

Receive-side counterpart of the four-digit 7-segment scan controller. It monitors a multiplexed anode/cathode bus (active-low), waits for each digit's pattern to settle, and decodes the cathode pattern back to a hex nibble. It then assembles the four nibbles into a 16-bit frame and flags invalid patterns and stale scans. It sits between the display pins (or the controller's outputs, in loopback test) and any logic that needs the displayed value.

## Interface
Parameters:
- SETTLE, 4: consecutive stable cycles (same anode, same seg) required before a digit is sampled; minimum 1.
- TIMEOUT, 65535: cycles without a completed frame before `stale` asserts.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- seg  input  7  cathodes, active-low; seg[6]=a … seg[0]=g.
- an  input  4  anodes, active-low; an[k]=0 selects digit k (digit 3 is the most significant nibble).
- value  output  16  last complete frame, {d3,d2,d1,d0}; reset 16'h0000.
- frame_valid  output  1  one-cycle pulse when `value` updates; reset 0.
- digit_mask  output  4  digits captured in the current, incomplete frame; reset 4'b0000.
- pattern_err  output  1  one-cycle pulse when a settled pattern is not in the table; reset 0.
- stale  output  1  level, high after TIMEOUT cycles with no frame; reset 0.

## Operation
- Decode table (seg, active-low, a..g) is fixed:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Anode classification: exactly one bit low means a valid digit k. 4'b1111, or two or more bits low, means blank.
- Per-dwell FSM:
  - BLANK: entered on a blank anode or on reset. Stable counter is cleared.
  - SETTLING: a valid anode is present. The counter increments each cycle that {an,seg} equals its previous-cycle value; any change reloads the counter to 1 and re-evaluates the anode.
  - When the counter reaches SETTLE, the FSM samples the pattern and moves to HELD.
  - HELD: no further sampling. The FSM leaves HELD on any change of an or seg, going to SETTLING or BLANK.
- Sample action, known pattern: nibble k is written into the shadow register and digit_mask[k] is set. A digit recaptured before the frame completes overwrites its nibble (latest wins).
- Sample action, unknown pattern: pattern_err pulses. The shadow register and mask are unchanged.
- Frame completion: when the mask would become 4'b1111, value is loaded from the shadow register and frame_valid pulses. digit_mask returns to 4'b0000 in the same update.
- Timeout counter: cleared on every frame_valid, saturates at TIMEOUT. stale = (count == TIMEOUT). stale drops on the next frame_valid.

## Timing
- Input changes at edge N; it is stable through edges N..N+SETTLE-1. The sample occurs at edge N+SETTLE-1, so the registered outputs (digit_mask, pattern_err) update after edge N+SETTLE-1.
- frame_valid and value update in that same cycle when the completing digit is sampled. There is no extra pipeline stage.
- No input synchronizer is included; seg and an must be synchronous to clk (the integrator adds a 2-FF sync for pin inputs).
- pattern_err and frame_valid are mutually exclusive in any cycle.
- rst in any state:
  - Next cycle: FSM is BLANK, counter is 0, shadow register, mask, value and timeout counter are cleared.
  - All outputs take their reset values.
  - Any partial frame is discarded.
- Dwell shorter than SETTLE cycles: no sample, no error.
- Repeated dwells of the same digit without a change in between: captured once per dwell only.

## Structure
- Package seven_seg_pkg holds:
  - the 16-entry pattern constants (shared with the scan controller's encoder);
  - the anode one-hot-low codes;
  - the FSM state typedef {BLANK, SETTLING, HELD}.
- One combinational sub-module, seven_seg_pattern_decode, maps seg to {hit, nibble[3:0]}.
- The FSM, counters and frame assembly are in the top module.

## Test plan
- Scan 16'hBEEF, dwell 10 cycles per digit, SETTLE=4 -> a single frame_valid after the 4th digit; value=16'hBEEF; digit_mask returns to 0.
- Digit 2 dwell of only 3 cycles, SETTLE=4 -> no capture; digit_mask stays 4'b1011 until digit 2 dwells for ≥4 cycles.
- seg=7'b1111110 held on an=4'b1110 -> one pattern_err pulse only (HELD blocks repeats); digit_mask[0] stays 0.
- an=4'b1100 or 4'b1111 for 20 cycles -> no capture, no error, FSM in BLANK.
- Assert rst after three digits of 16'h1234 -> digit_mask=0 and value=0 next cycle; a subsequent full 16'h5678 scan yields value=16'h5678.
- TIMEOUT=100, no input activity -> stale rises at cycle 100; the next completed frame clears stale in the frame_valid cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 4-digit active-low 7-segment display path:
// cathode patterns, anode codes, capture FSM state and anode classification.
package seven_seg_pkg;

    // Cathode patterns for nibbles 0..F, active-low, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Anode code that selects digit k (exactly one bit low).
    localparam logic [3:0] AN_DIGIT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [1:0] {
        BLANK    = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } an_info_t;

    // Anything other than a single low bit (all high, or several low) is blank.
    function automatic an_info_t an_classify(input logic [3:0] an);
        an_info_t info;
        info = '0;
        for (int k = 0; k < 4; k++) begin
            if (an == AN_DIGIT[k]) begin
                info.valid = 1'b1;
                info.idx   = 2'(k);
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational reverse lookup of an active-low cathode pattern to its nibble;
// hit_o is low when the pattern is not one of the sixteen hex glyphs.
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Watches a multiplexed active-low anode/cathode bus, samples each digit once
// it has been stable for SETTLE cycles and assembles the four nibbles into a frame.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_mask,
    output logic        pattern_err,
    output logic        stale,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      an_prev_q;
    logic [6:0]      seg_prev_q;
    logic [15:0]     shadow_q, shadow_d;
    logic [15:0]     value_q, value_d;
    logic [3:0]      mask_q, mask_d;
    logic            fv_q, fv_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    an_info_t        an_info;
    logic            same;
    logic            sample;
    logic            dec_hit;
    logic [3:0]      dec_nibble;
    logic [3:0]      mask_set;
    logic [15:0]     shadow_upd;

    seven_seg_pattern_decode u_decode (
        .seg_i    (seg),
        .hit_o    (dec_hit),
        .nibble_o (dec_nibble)
    );

    // Dwell FSM: the sample fires on the edge where the stable count reaches SETTLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        an_info = an_classify(an);
        same    = (an == an_prev_q) && (seg == seg_prev_q);

        case (state_q)
            BLANK: begin
                if (an_info.valid) begin
                    state_d = SETTLING;
                    cnt_d   = CW'(1);
                end
            end
            SETTLING, HELD: begin
                if (!same) begin
                    if (an_info.valid) begin
                        state_d = SETTLING;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end else if (state_q == SETTLING) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase

        if (state_d == SETTLING && cnt_d == CW'(SETTLE)) begin
            sample  = 1'b1;
            state_d = HELD;
        end
    end

    // Frame assembly and staleness tracking.
    always_comb begin
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        value_d    = value_q;
        fv_d       = 1'b0;
        err_d      = 1'b0;
        tmo_d      = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
        mask_set   = mask_q | (4'b0001 << an_info.idx);
        shadow_upd = shadow_q;
        shadow_upd[{an_info.idx, 2'b00} +: 4] = dec_nibble;

        if (sample) begin
            if (dec_hit) begin
                shadow_d = shadow_upd;
                if (mask_set == 4'b1111) begin
                    value_d = shadow_upd;
                    fv_d    = 1'b1;
                    mask_d  = 4'b0000;
                    tmo_d   = '0;
                end else begin
                    mask_d  = mask_set;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            an_prev_q  <= 4'hF;
            seg_prev_q <= 7'h7F;
            shadow_q   <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            an_prev_q  <= an;
            seg_prev_q <= seg;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign digit_mask  = mask_q;
    assign pattern_err = err_q;
    assign stale       = (tmo_q == TW'(TIMEOUT));
    assign dbg_state   = state_q;

endmodule
